// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared definitions for the EX/MEM pipeline register: NZCV bit layout,
// flag-write select positions, condition encodings and the per-stage
// control bundle.
package ex_mem_pipe_reg_pkg;

  // Default widths
  localparam int DATA_WIDTH_DEF = 32;
  localparam int RA_WIDTH_DEF   = 4;
  localparam int CNT_WIDTH_DEF  = 16;

  // NZCV bit positions inside the 4-bit flag vector
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  // FlagW select bits: [1] updates N,Z and [0] updates C,V
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

  // Condition field encodings; 4'hF is unused
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE
  } cond_e;

  // Control bundle carried from EX into MEM. flagw and aluflags are
  // shadow copies used only to build the flag commit.
  typedef struct packed {
    logic       regw;
    logic       exec;
    logic       memtoreg;
    logic [3:0] cond;
    logic [1:0] flagw;
    logic [3:0] aluflags;
  } ctrl_t;

endpackage : ex_mem_pipe_reg_pkg

// File: rtl/ex_mem_pipe_reg_nzcv_flag_reg.sv
// Architectural NZCV flag register. N,Z and C,V are written as two
// independent pairs so a partial update leaves the other pair intact.
module nzcv_flag_reg
  import ex_mem_pipe_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nz_en_i,
  input  logic       cv_en_i,
  input  logic [3:0] flags_i,
  output logic [3:0] flags_o
);

  logic [1:0] nz_q;
  logic [1:0] cv_q;

  // N,Z pair: cleared on reset, loaded only when its enable is set
  // NOTE: state is written with <= so every flop samples pre-edge values;
  //       a blocking = here would let later statements see the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_q <= 2'b00;
    end else if (nz_en_i) begin
      nz_q <= flags_i[NZCV_N:NZCV_Z];
    end
  end

  // C,V pair: cleared on reset, loaded only when its enable is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_q <= 2'b00;
    end else if (cv_en_i) begin
      cv_q <= flags_i[NZCV_C:NZCV_V];
    end
  end

  assign flags_o = {nz_q, cv_q};

endmodule : nzcv_flag_reg

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register. Captures the EX-stage result and control,
// owns the architectural NZCV flags seen by the MEM condition unit, and
// counts instructions annulled by a failed condition.
//
// Priority at each edge is Flush > Stall > capture for the incoming
// instruction. The flag commit and the annul count look only at the
// instruction leaving MEM, so Flush never blocks them; Stall does,
// because a stalled instruction has not left MEM yet.
module ex_mem_pipe_reg
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RA_WIDTH   = RA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  E_RegW,
  input  logic                  E_Exec,
  input  logic                  E_MemtoReg,
  input  logic [3:0]            E_Cond,
  input  logic [1:0]            E_FlagW,
  input  logic [3:0]            E_ALUFlags,
  input  logic [DATA_WIDTH-1:0] E_ALUResult,
  input  logic [DATA_WIDTH-1:0] E_WriteData,
  input  logic [RA_WIDTH-1:0]   E_WA3,
  input  logic                  M_CondEx,
  output logic                  M_RegW,
  output logic                  M_Exec,
  output logic                  M_MemtoReg,
  output logic [3:0]            M_Cond,
  output logic [3:0]            M_Flags,
  output logic [DATA_WIDTH-1:0] M_ALUResult,
  output logic [DATA_WIDTH-1:0] M_WriteData,
  output logic [RA_WIDTH-1:0]   M_WA3,
  output logic [CNT_WIDTH-1:0]  AnnulCount
);

  // ---------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------
  ctrl_t                 ctrl_d,   ctrl_q;
  logic [DATA_WIDTH-1:0] result_d, result_q;
  logic [DATA_WIDTH-1:0] wdata_d,  wdata_q;
  logic [RA_WIDTH-1:0]   wa3_d,    wa3_q;
  logic [CNT_WIDTH-1:0]  annul_d,  annul_q;

  ctrl_t e_ctrl;

  // Leaving-instruction qualifiers
  logic commit;
  logic annul;

  assign e_ctrl = '{
    regw:     E_RegW,
    exec:     E_Exec,
    memtoreg: E_MemtoReg,
    cond:     E_Cond,
    flagw:    E_FlagW,
    aluflags: E_ALUFlags
  };

  // Next-state for the MEM stage contents: bubble, hold or capture
  // NOTE: every _d gets its hold value first so no path leaves it
  //       unassigned; a missing default would infer a latch.
  always_comb begin
    ctrl_d   = ctrl_q;
    result_d = result_q;
    wdata_d  = wdata_q;
    wa3_d    = wa3_q;
    if (Flush) begin
      ctrl_d   = '0;
      result_d = '0;
      wdata_d  = '0;
      wa3_d    = '0;
    end else if (!Stall) begin
      ctrl_d   = e_ctrl;
      result_d = E_ALUResult;
      wdata_d  = E_WriteData;
      wa3_d    = E_WA3;
    end
  end

  // The instruction in MEM leaves on a non-stalled edge; whether it
  // commits flags or is counted as annulled depends on the condition unit.
  assign commit = ctrl_q.exec &  M_CondEx & ~Stall;
  assign annul  = ctrl_q.exec & ~M_CondEx & ~Stall;

  // Annulled-instruction counter, saturating at all-ones
  always_comb begin
    annul_d = annul_q;
    if (annul && (annul_q != {CNT_WIDTH{1'b1}})) begin
      annul_d = annul_q + CNT_WIDTH'(1);
    end
  end

  // Stage and counter state, cleared asynchronously
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ctrl_q   <= '0;
      result_q <= '0;
      wdata_q  <= '0;
      wa3_q    <= '0;
      annul_q  <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      wdata_q  <= wdata_d;
      wa3_q    <= wa3_d;
      annul_q  <= annul_d;
    end
  end

  // ---------------------------------------------------------------------
  // Architectural flags: written on the same edge the next instruction
  // enters MEM, so it sees the new flags without a bypass.
  // ---------------------------------------------------------------------
  nzcv_flag_reg u_flags (
    .clk     (CLK),
    .rst_n   (RST_N),
    .nz_en_i (commit & ctrl_q.flagw[FLAGW_NZ]),
    .cv_en_i (commit & ctrl_q.flagw[FLAGW_CV]),
    .flags_i (ctrl_q.aluflags),
    .flags_o (M_Flags)
  );

  // ---------------------------------------------------------------------
  // Outputs come straight from registers
  // ---------------------------------------------------------------------
  assign M_RegW      = ctrl_q.regw;
  assign M_Exec      = ctrl_q.exec;
  assign M_MemtoReg  = ctrl_q.memtoreg;
  assign M_Cond      = ctrl_q.cond;
  assign M_ALUResult = result_q;
  assign M_WriteData = wdata_q;
  assign M_WA3       = wa3_q;
  assign AnnulCount  = annul_q;

endmodule : ex_mem_pipe_reg

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg. Each clocked step pushes the
// expected post-edge MEM state to a scoreboard; after the edge the entry
// is popped and compared against the DUT outputs.
module tb_ex_mem_pipe_reg;
  import ex_mem_pipe_reg_pkg::*;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int CW = 16;

  typedef struct packed {
    logic          regw;
    logic          exec;
    logic          memtoreg;
    logic [3:0]    cond;
    logic [1:0]    flagw;
    logic [3:0]    aluflags;
    logic [DW-1:0] result;
    logic [DW-1:0] wdata;
    logic [RW-1:0] wa3;
  } instr_t;

  typedef struct {
    instr_t        m;
    logic [3:0]    flags;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          CLK;
  logic          RST_N;
  logic          Stall, Flush;
  logic          E_RegW, E_Exec, E_MemtoReg;
  logic [3:0]    E_Cond;
  logic [1:0]    E_FlagW;
  logic [3:0]    E_ALUFlags;
  logic [DW-1:0] E_ALUResult, E_WriteData;
  logic [RW-1:0] E_WA3;
  logic          M_CondEx;
  logic          M_RegW, M_Exec, M_MemtoReg;
  logic [3:0]    M_Cond, M_Flags;
  logic [DW-1:0] M_ALUResult, M_WriteData;
  logic [RW-1:0] M_WA3;
  logic [CW-1:0] AnnulCount;

  ex_mem_pipe_reg #(.DATA_WIDTH(DW), .RA_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .Stall(Stall), .Flush(Flush),
    .E_RegW(E_RegW), .E_Exec(E_Exec), .E_MemtoReg(E_MemtoReg),
    .E_Cond(E_Cond), .E_FlagW(E_FlagW), .E_ALUFlags(E_ALUFlags),
    .E_ALUResult(E_ALUResult), .E_WriteData(E_WriteData), .E_WA3(E_WA3),
    .M_CondEx(M_CondEx),
    .M_RegW(M_RegW), .M_Exec(M_Exec), .M_MemtoReg(M_MemtoReg),
    .M_Cond(M_Cond), .M_Flags(M_Flags), .M_ALUResult(M_ALUResult),
    .M_WriteData(M_WriteData), .M_WA3(M_WA3), .AnnulCount(AnnulCount)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference state and scoreboard
  instr_t        mdl_m;
  logic [3:0]    mdl_flags;
  logic [CW-1:0] mdl_cnt;
  exp_t          sb_q[$];
  int            n_cmp;
  int            n_bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic exec, input logic regw, input logic [1:0] flagw,
                                input logic [3:0] af, input logic [3:0] cond,
                                input logic [DW-1:0] res, input logic [RW-1:0] wa3);
    instr_t t;
    t.regw     = regw;
    t.exec     = exec;
    t.memtoreg = res[0];
    t.cond     = cond;
    t.flagw    = flagw;
    t.aluflags = af;
    t.result   = res;
    t.wdata    = ~res;
    t.wa3      = wa3;
    return t;
  endfunction

  task automatic drive(input instr_t e, input logic stall, input logic flush, input logic condex);
    E_RegW      = e.regw;
    E_Exec      = e.exec;
    E_MemtoReg  = e.memtoreg;
    E_Cond      = e.cond;
    E_FlagW     = e.flagw;
    E_ALUFlags  = e.aluflags;
    E_ALUResult = e.result;
    E_WriteData = e.wdata;
    E_WA3       = e.wa3;
    Stall       = stall;
    Flush       = flush;
    M_CondEx    = condex;
  endtask

  task automatic compare_all(input string pfx, input exp_t x);
    check({pfx, ".RegW"},     M_RegW,      x.m.regw);
    check({pfx, ".Exec"},     M_Exec,      x.m.exec);
    check({pfx, ".MemtoReg"}, M_MemtoReg,  x.m.memtoreg);
    check({pfx, ".Cond"},     M_Cond,      x.m.cond);
    check({pfx, ".Flags"},    M_Flags,     x.flags);
    check({pfx, ".ALURes"},   M_ALUResult, x.m.result);
    check({pfx, ".WData"},    M_WriteData, x.m.wdata);
    check({pfx, ".WA3"},      M_WA3,       x.m.wa3);
    check({pfx, ".Annul"},    AnnulCount,  x.cnt);
  endtask

  // One clock edge: predict, push, clock, pop, compare
  task automatic step(input string pfx, input instr_t e, input logic stall,
                      input logic flush, input logic condex, input bit chk);
    logic commit, annul;
    exp_t x;
    drive(e, stall, flush, condex);
    commit = mdl_m.exec & condex & ~stall;
    annul  = mdl_m.exec & ~condex & ~stall;
    if (commit && mdl_m.flagw[1]) mdl_flags[3:2] = mdl_m.aluflags[3:2];
    if (commit && mdl_m.flagw[0]) mdl_flags[1:0] = mdl_m.aluflags[1:0];
    if (annul && (mdl_cnt != {CW{1'b1}})) mdl_cnt = mdl_cnt + 1'b1;
    if (flush)       mdl_m = '0;
    else if (!stall) mdl_m = e;
    x.m = mdl_m; x.flags = mdl_flags; x.cnt = mdl_cnt;
    sb_q.push_back(x);
    @(posedge CLK);
    #1;
    x = sb_q.pop_front();
    if (chk) compare_all(pfx, x);
  endtask

  task automatic reset_model();
    mdl_m = '0; mdl_flags = 4'b0000; mdl_cnt = '0;
    sb_q.delete();
  endtask

  // Bound on total run time
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  instr_t idle, a, b, c, d, ins;

  initial begin
    n_cmp = 0; n_bad = 0;
    idle = '0;
    reset_model();
    drive(idle, 1'b0, 1'b0, 1'b0);
    RST_N = 1'b0;

    // Reset state
    #12;
    compare_all("reset", '{m: '0, flags: 4'b0000, cnt: '0});
    @(negedge CLK);
    RST_N = 1'b1;
    step("idle", idle, 1'b0, 1'b0, 1'b0, 1'b1);

    // Pass-through with no change during the capture cycle
    ins = mk(1'b1, 1'b1, 2'b00, 4'b0000, COND_AL, 32'hDEADBEEF, 4'd7);
    drive(ins, 1'b0, 1'b0, 1'b1);
    #2;
    check("pt_same_cycle.ALURes", M_ALUResult, 32'h0);
    check("pt_same_cycle.WA3",    M_WA3,       4'd0);
    step("pt", ins, 1'b0, 1'b0, 1'b1, 1'b1);
    check("pt.ALURes_const", M_ALUResult, 32'hDEADBEEF);
    check("pt.WA3_const",    M_WA3,       4'd7);
    check("pt.RegW_const",   M_RegW,      1'b1);

    // Flag-setting instruction followed by a conditional
    a = mk(1'b1, 1'b1, 2'b11, 4'b0100, COND_AL, 32'h0000_1111, 4'd1);
    b = mk(1'b1, 1'b1, 2'b00, 4'b0000, COND_EQ, 32'h0000_2222, 4'd2);
    step("fs_a", a, 1'b0, 1'b0, 1'b1, 1'b1);
    step("fs_b", b, 1'b0, 1'b0, 1'b1, 1'b1);
    check("fs.Flags_const", M_Flags, 4'b0100);
    check("fs.Cond_const",  M_Cond,  COND_EQ);

    // Partial update: 1111 then C,V only with 00 -> 1100
    a = mk(1'b1, 1'b0, 2'b11, 4'b1111, COND_AL, 32'h33, 4'd3);
    b = mk(1'b1, 1'b0, 2'b01, 4'b0000, COND_AL, 32'h44, 4'd4);
    step("pu_a", a, 1'b0, 1'b0, 1'b1, 1'b1);
    step("pu_b", b, 1'b0, 1'b0, 1'b1, 1'b1);
    check("pu.Flags_1111", M_Flags, 4'b1111);
    step("pu_c", idle, 1'b0, 1'b0, 1'b1, 1'b1);
    check("pu.Flags_1100", M_Flags, 4'b1100);

    // Stall with a committing instruction in MEM, then release
    c = mk(1'b1, 1'b1, 2'b11, 4'b1000, COND_AL, 32'hC0DE_0001, 4'd5);
    d = mk(1'b1, 1'b1, 2'b00, 4'b0110, COND_NE, 32'hC0DE_0002, 4'd6);
    step("st_load", c, 1'b0, 1'b0, 1'b1, 1'b1);
    step("st_1", d, 1'b1, 1'b0, 1'b1, 1'b1);
    step("st_2", d, 1'b1, 1'b0, 1'b1, 1'b1);
    check("st.held_ALURes", M_ALUResult, 32'hC0DE_0001);
    check("st.Flags_held",  M_Flags,     4'b1100);
    step("st_rel", d, 1'b0, 1'b0, 1'b1, 1'b1);
    check("st.Flags_commit", M_Flags, 4'b1000);
    step("st_after", idle, 1'b0, 1'b0, 1'b1, 1'b1);
    check("st.Flags_once", M_Flags, 4'b1000);

    // Stall together with Flush: bubble wins
    step("sf_load", d, 1'b0, 1'b0, 1'b1, 1'b1);
    step("sf", c, 1'b1, 1'b1, 1'b1, 1'b1);
    check("sf.Exec_const",   M_Exec,      1'b0);
    check("sf.ALURes_const", M_ALUResult, 32'h0);

    // Flush does not block the commit of the leaving instruction
    a = mk(1'b1, 1'b0, 2'b10, 4'b0100, COND_AL, 32'h55, 4'd8);
    step("fl_load", a, 1'b0, 1'b0, 1'b1, 1'b1);
    step("fl", c, 1'b0, 1'b1, 1'b1, 1'b1);
    check("fl.Flags_const", M_Flags, 4'b0100);

    // Asynchronous reset mid-operation with M_Exec=1 and flags 1010
    a = mk(1'b1, 1'b1, 2'b11, 4'b1010, COND_AL, 32'h66, 4'd9);
    b = mk(1'b1, 1'b1, 2'b00, 4'b0000, COND_AL, 32'h77, 4'd10);
    step("rm_a", a, 1'b0, 1'b0, 1'b1, 1'b1);
    step("rm_b", b, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rm.pre_Flags", M_Flags, 4'b1010);
    check("rm.pre_Exec",  M_Exec,  1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    reset_model();
    compare_all("rm_async", '{m: '0, flags: 4'b0000, cnt: '0});
    @(negedge CLK);
    RST_N = 1'b1;

    // Annulled instructions: flags unchanged, counter counts
    a = mk(1'b1, 1'b1, 2'b11, 4'b1100, COND_AL, 32'h88, 4'd11);
    b = mk(1'b1, 1'b1, 2'b11, 4'b0011, COND_EQ, 32'h99, 4'd12);
    step("an_a", a, 1'b0, 1'b0, 1'b1, 1'b1);
    step("an_b", b, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("an", b, 1'b0, 1'b0, 1'b0, 1'b1);
    check("an.Count3", AnnulCount, 16'd3);
    check("an.Flags",  M_Flags,    4'b1100);

    // Bubbles never count, whatever M_CondEx says
    step("bub_in", idle, 1'b0, 1'b0, 1'b0, 1'b1);
    step("bub", idle, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bub.Count", AnnulCount, 16'd4);

    // Drive the counter to saturation, then one more annul
    step("sat_in", b, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 65531; i++) step("sat_run", b, 1'b0, 1'b0, 1'b0, 1'b0);
    step("sat_full", b, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sat.Full", AnnulCount, 16'hFFFF);
    step("sat_more", b, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sat.Hold", AnnulCount, 16'hFFFF);
    check("sat.Flags", M_Flags,   4'b1100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ex_mem_pipe_reg
